// File: rtl/q_pkg.sv
// q_pkg: shared state encoding and default parameters for the q ingress framer.
package q_pkg;
    typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} q_framer_state_t;
    localparam int Q_FRAMER_MAX_LEN_DFLT = 16;
    localparam int Q_FRAMER_CNT_W_DFLT   = 16;
endpackage

// File: rtl/q_sat_cnt.sv
// q_sat_cnt: saturating up-counter that holds at all-ones.
module q_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt_r
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else if (i_inc && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
    end
    assign o_cnt_r = cnt_q;
endmodule

// File: rtl/q_ingress_framer.sv
// q_ingress_framer: repairs or drops malformed vld/sop/eop framing, caps packet length,
// and counts emitted packets and framing errors.
module q_ingress_framer
    import q_pkg::*;
#(
    parameter int MAX_LEN = Q_FRAMER_MAX_LEN_DFLT,
    parameter int CNT_W   = Q_FRAMER_CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic             i_sop,
    input  logic             i_eop,
    output logic             o_vld_r,
    output logic             o_sop_r,
    output logic             o_eop_r,
    output logic             o_err_r,
    output logic             o_busy_r,
    output logic [CNT_W-1:0] o_pkt_cnt_r,
    output logic [CNT_W-1:0] o_err_cnt_r
);
    localparam int LW = $clog2(MAX_LEN + 1);

    q_framer_state_t state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic            vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d, busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            err_q   <= err_d;
            busy_q  <= state_d == IN_PKT;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        vld_d   = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        if (i_vld) begin
            case (state_q)
                IN_PKT: begin
                    vld_d = 1'b1;
                    if (i_sop) begin
                        // premature sop closes the open packet; the new one is sacrificed
                        eop_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = i_eop ? IDLE : DISCARD;
                    end else if (i_eop) begin
                        eop_d   = 1'b1;
                        state_d = IDLE;
                    end else if (len_q == LW'(MAX_LEN - 1)) begin
                        eop_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        len_d = len_q + LW'(1);
                    end
                end
                default: begin
                    if (i_sop) begin
                        vld_d   = 1'b1;
                        sop_d   = 1'b1;
                        eop_d   = i_eop;
                        state_d = i_eop ? IDLE : IN_PKT;
                        len_d   = i_eop ? LW'(0) : LW'(1);
                    end else if (state_q == IDLE) begin
                        err_d   = 1'b1;
                        state_d = i_eop ? IDLE : DISCARD;
                    end else if (i_eop) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    q_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (vld_d & eop_d),
        .o_cnt_r (o_pkt_cnt_r)
    );

    q_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (err_d),
        .o_cnt_r (o_err_cnt_r)
    );

    assign o_vld_r  = vld_q;
    assign o_sop_r  = sop_q;
    assign o_eop_r  = eop_q;
    assign o_err_r  = err_q;
    assign o_busy_r = busy_q;
endmodule
